// File: rtl/sa2_operand_loader.sv
// Operand loader for the 2x2 systolic-array convolution stage.
// Assembles 16 activation bytes and 9 filter bytes from a valid/ready byte
// stream, then holds active_sa2 high until the array signals done_sa2 or
// the completion watchdog expires.
module sa2_operand_loader #(
   parameter int TIMEOUT = 64   // RUN cycles allowed before abort; array needs 29
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   output logic [127:0] a_flat,
   output logic [71:0]  b_flat,
   output logic         active_sa2,
   input  logic         done_sa2,
   output logic         err_timeout,
   output logic [7:0]   frame_cnt
);

   localparam int WD_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      RUN    = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [3:0]      byte_cnt;
   logic [WD_W-1:0] wd;
   logic            xfer;
   logic            last_a, last_b;
   logic            done_hit, timeout_hit;

   // Only the load phases accept bytes; held low through reset.
   assign in_ready    = !rst && (state != RUN);
   assign xfer        = in_valid && in_ready;
   assign last_a      = (state == LOAD_A) && (byte_cnt == 4'd15);
   assign last_b      = (state == LOAD_B) && (byte_cnt == 4'd8);
   assign done_hit    = (state == RUN) && done_sa2;
   // done_sa2 takes priority over a watchdog expiry on the same edge.
   assign timeout_hit = (state == RUN) && !done_sa2 && (wd == WD_W'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD_A;
      else     state <= state_nxt;
   end

   // Next-state: advance at the last byte of each load phase, leave RUN on done or timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD_A:  if (xfer && last_a) state_nxt = LOAD_B;
         LOAD_B:  if (xfer && last_b) state_nxt = RUN;
         RUN:     if (done_hit || timeout_hit) state_nxt = LOAD_A;
         default: state_nxt = LOAD_A;
      endcase
   end

   // Byte index within the current load phase; restarts at each phase boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               byte_cnt <= 4'd0;
      else if (xfer) begin
         if (last_a || last_b) byte_cnt <= 4'd0;
         else                  byte_cnt <= byte_cnt + 4'd1;
      end
   end

   // Operand capture: each accepted byte lands in its row-major slot; held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_flat <= '0;
         b_flat <= '0;
      end else if (xfer) begin
         for (int i = 0; i < 16; i++)
            if (state == LOAD_A && byte_cnt == 4'(i)) a_flat[8*i +: 8] <= in_data;
         for (int j = 0; j < 9; j++)
            if (state == LOAD_B && byte_cnt == 4'(j)) b_flat[8*j +: 8] <= in_data;
      end
   end

   // Run control: launch the array, watch for completion, count frames, flag aborts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_sa2  <= 1'b0;
         wd          <= '0;
         err_timeout <= 1'b0;
         frame_cnt   <= 8'd0;
      end else if (xfer && last_b) begin
         active_sa2 <= 1'b1;
         wd         <= '0;
      end else if (done_hit) begin
         active_sa2 <= 1'b0;
         frame_cnt  <= frame_cnt + 8'd1;
      end else if (timeout_hit) begin
         active_sa2  <= 1'b0;
         err_timeout <= 1'b1;
      end else if (state == RUN) begin
         wd <= wd + 1'b1;
      end
   end

endmodule

// File: tb/tb_sa2_operand_loader.sv
// Self-checking bench for sa2_operand_loader: a byte-count/run-length model
// of a frame is compared against the DUT every cycle, with literal anchors.
module tb_sa2_operand_loader;

   localparam int TIMEOUT = 64;

   logic         clk, rst;
   logic         in_valid, in_ready, done_sa2;
   logic [7:0]   in_data;
   logic [127:0] a_flat;
   logic [71:0]  b_flat;
   logic         active_sa2, err_timeout;
   logic [7:0]   frame_cnt;

   int checks   = 0;
   int failures = 0;

   sa2_operand_loader #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .a_flat(a_flat), .b_flat(b_flat),
      .active_sa2(active_sa2), .done_sa2(done_sa2),
      .err_timeout(err_timeout), .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame model: bytes 0..15 are activations, 16..24 filter; after 25 bytes the
   // array runs until done or until TIMEOUT run cycles have elapsed.
   logic [127:0] m_a;
   logic [71:0]  m_b;
   logic         m_run, m_err;
   logic [7:0]   m_frame;
   int           m_n, m_rc;

   // Model update from the same inputs the DUT sees at each edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_a <= '0; m_b <= '0; m_run <= 1'b0; m_err <= 1'b0;
         m_frame <= 8'd0; m_n <= 0; m_rc <= 0;
      end else if (!m_run) begin
         if (in_valid) begin
            if (m_n < 16) m_a[8*m_n +: 8] <= in_data;
            else          m_b[8*(m_n-16) +: 8] <= in_data;
            if (m_n == 24) begin m_n <= 0; m_run <= 1'b1; m_rc <= 0; end
            else m_n <= m_n + 1;
         end
      end else begin
         if (done_sa2) begin
            m_run <= 1'b0; m_frame <= m_frame + 8'd1;
         end else if (m_rc + 1 == TIMEOUT) begin
            m_run <= 1'b0; m_err <= 1'b1;
         end else m_rc <= m_rc + 1;
      end
   end

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
      end
   endtask

   // Cycle-by-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      check("in_ready",    128'(in_ready),    128'(!rst && !m_run));
      check("active_sa2",  128'(active_sa2),  128'(m_run));
      check("err_timeout", 128'(err_timeout), 128'(m_err));
      check("frame_cnt",   128'(frame_cnt),   128'(m_frame));
      check("a_flat",      a_flat,            m_a);
      check("b_flat",      128'(b_flat),      128'(m_b));
   end

   // Stream 25 bytes (1..25 when seq, else random), optionally with random gaps.
   task automatic send_bytes(input int count, input bit seq, input bit gaps);
      for (int k = 0; k < count; k++) begin
         while (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0; in_data = 8'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = seq ? 8'(k + 1) : 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // Drive done_sa2 on the run cycle whose index (from 0) equals done_at; -1 = never.
   task automatic run_wait(input int done_at, output int ncyc);
      ncyc = 0;
      done_sa2 = m_run && (m_rc == done_at);
      while (m_run && ncyc < 300) begin
         @(posedge clk); #1;
         ncyc++;
         done_sa2 = m_run && (m_rc == done_at);
      end
      checks++;
      if (m_run) begin
         failures++;
         $display("FAIL run_wait_bound t=%0t got=running exp=finished", $time);
      end
      done_sa2 = 1'b0;
   endtask

   // Assert reset away from an edge and confirm outputs clear without a clock.
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      check({tag, "_a"},      a_flat, 128'd0);
      check({tag, "_b"},      128'(b_flat), 128'd0);
      check({tag, "_active"}, 128'(active_sa2), 128'd0);
      check({tag, "_ready"},  128'(in_ready), 128'd0);
      check({tag, "_err"},    128'(err_timeout), 128'd0);
      check({tag, "_frame"},  128'(frame_cnt), 128'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check_basic_bytes(input string tag);
      check({tag, "_a11"}, 128'(a_flat[7:0]),    128'd1);
      check({tag, "_a44"}, 128'(a_flat[127:120]), 128'd16);
      check({tag, "_b11"}, 128'(b_flat[7:0]),    128'd17);
      check({tag, "_b33"}, 128'(b_flat[71:64]),  128'd25);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; done_sa2 = 1'b0;
      #1;
      check("rst_ready", 128'(in_ready), 128'd0);
      check("rst_frame", 128'(frame_cnt), 128'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic frame: back-to-back bytes, done on run cycle 29.
      send_bytes(25, 1'b1, 1'b0);
      check("basic_active_rise", 128'(active_sa2), 128'd1);
      run_wait(28, n);
      check("basic_run_len", 128'(n), 128'd29);
      check("basic_active_fall", 128'(active_sa2), 128'd0);
      check("basic_frame", 128'(frame_cnt), 128'd1);
      check_basic_bytes("basic");

      // Gapped load, then a held 0xFF during RUN must not transfer.
      send_bytes(25, 1'b1, 1'b1);
      in_valid = 1'b1; in_data = 8'hFF;
      run_wait(28, n);
      in_valid = 1'b0;
      check("gap_frame", 128'(frame_cnt), 128'd2);
      check_basic_bytes("gap");

      // Reset after 10 bytes, then a full frame from byte 0.
      send_bytes(10, 1'b0, 1'b0);
      async_reset("rst_load");
      send_bytes(25, 1'b1, 1'b1);
      run_wait(28, n);
      check_basic_bytes("post_rst");
      check("post_rst_frame", 128'(frame_cnt), 128'd1);

      // Reset during RUN.
      send_bytes(25, 1'b0, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      async_reset("rst_run");

      // Watchdog: no done ever.
      send_bytes(25, 1'b0, 1'b1);
      run_wait(-1, n);
      check("wd_run_len", 128'(n), 128'd64);
      check("wd_err", 128'(err_timeout), 128'd1);
      check("wd_frame", 128'(frame_cnt), 128'd0);
      check("wd_ready", 128'(in_ready), 128'd1);
      send_bytes(25, 1'b0, 1'b0);
      run_wait(10, n);
      check("wd_next_frame", 128'(frame_cnt), 128'd1);
      check("wd_err_sticky", 128'(err_timeout), 128'd1);

      // Done and timeout on the same edge: done wins.
      async_reset("rst_coll");
      send_bytes(25, 1'b0, 1'b0);
      run_wait(TIMEOUT - 1, n);
      check("coll_run_len", 128'(n), 128'd64);
      check("coll_frame", 128'(frame_cnt), 128'd1);
      check("coll_err", 128'(err_timeout), 128'd0);

      // Wrap: 256 frames with immediate done.
      async_reset("rst_wrap");
      for (int f = 0; f < 256; f++) begin
         send_bytes(25, 1'b0, 1'b0);
         run_wait(0, n);
      end
      check("wrap_frame", 128'(frame_cnt), 128'd0);

      // Spurious done while loading is ignored.
      done_sa2 = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      done_sa2 = 1'b0;
      check("spurious_frame", 128'(frame_cnt), 128'd0);
      check("spurious_active", 128'(active_sa2), 128'd0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_bound t=%0t got=running exp=finished", $time);
      $fatal(1);
   end

endmodule
